// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma -- sprite OAM DMA engine.
//
// A CPU write to DMA_REG latches the written byte as a source page. The engine
// then takes the bus: one HALT cycle, an optional ALIGN cycle, then 256
// READ/WRITE pairs. Each pair reads {page, idx} and writes that byte to
// OAM_DATA_REG. dma_done pulses for one cycle once the transfer is back in IDLE.
//
// Configuration macro: OAM_DMA_ALIGN_EN
//   defined   : a free-running parity bit decides whether HALT is followed by
//               an ALIGN cycle (parity 1) or goes straight to READ (parity 0).
//   undefined : HALT always goes to READ and the parity logic is not built.
//
// Ports
//   cpu_clk    in   1  CPU clock; all state changes on its rising edge
//   rst_n      in   1  asynchronous active-low reset
//   cpu_addr   in  16  CPU address bus
//   cpu_wdata  in   8  CPU write data
//   cpu_wen    in   1  CPU write enable
//   mem_rdata  in   8  bus read data for the address driven this cycle
//   dma_active out  1  DMA owns the bus (CPU stalled)
//   dma_addr   out 16  DMA bus address
//   dma_wen    out  1  DMA write enable
//   dma_wdata  out  8  DMA write data
//   dma_done   out  1  one-cycle pulse after the last OAM write
//
// All outputs are registers. They are computed from the next state, so they
// line up with the state register and clear immediately on reset.
// -----------------------------------------------------------------------------
module oam_dma #(
  parameter logic [15:0] DMA_REG      = 16'h4014,
  parameter logic [15:0] OAM_DATA_REG = 16'h2004
) (
  input  logic        cpu_clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_wen,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active,
  output logic [15:0] dma_addr,
  output logic        dma_wen,
  output logic [7:0]  dma_wdata,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;

  logic        dma_active_q, dma_active_d;
  logic [15:0] dma_addr_q, dma_addr_d;
  logic        dma_wen_q, dma_wen_d;
  logic [7:0]  dma_wdata_q, dma_wdata_d;
  logic        dma_done_q, dma_done_d;

`ifdef OAM_DMA_ALIGN_EN
  logic        parity_q, parity_d;

  // Free-running parity toggle, used to decide whether an ALIGN cycle is needed.
  always_comb begin
    parity_d = ~parity_q;
  end

  // Parity register.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

  // Next-state logic for the transfer sequencer and its datapath registers.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        // The page is only latched here, so triggers during a transfer are ignored.
        if (cpu_wen && (cpu_addr == DMA_REG)) begin
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = HALT;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
`ifdef OAM_DMA_ALIGN_EN
        if (parity_q) begin
          state_d = ALIGN;
        end else begin
          state_d = READ;
        end
`else
        state_d = READ;
`endif
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        data_d  = mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        // idx wraps within the page; it never carries into page.
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    dma_active_d = (state_d != IDLE);
    dma_addr_d   = 16'h0000;
    dma_wen_d    = 1'b0;
    dma_wdata_d  = 8'h00;
    case (state_d)
      READ: begin
        dma_addr_d = {page_d, idx_d};
      end
      WRITE: begin
        dma_addr_d  = OAM_DATA_REG;
        dma_wen_d   = 1'b1;
        dma_wdata_d = data_d;
      end
      default: begin
        dma_addr_d = 16'h0000;
      end
    endcase
    dma_done_d = (state_q == WRITE) && (idx_q == 8'hFF);
  end

  // Sequencer state, datapath and registered outputs.
  always_ff @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      page_q       <= 8'h00;
      idx_q        <= 8'h00;
      data_q       <= 8'h00;
      dma_active_q <= 1'b0;
      dma_addr_q   <= 16'h0000;
      dma_wen_q    <= 1'b0;
      dma_wdata_q  <= 8'h00;
      dma_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      page_q       <= page_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      dma_active_q <= dma_active_d;
      dma_addr_q   <= dma_addr_d;
      dma_wen_q    <= dma_wen_d;
      dma_wdata_q  <= dma_wdata_d;
      dma_done_q   <= dma_done_d;
    end
  end

  assign dma_active = dma_active_q;
  assign dma_addr   = dma_addr_q;
  assign dma_wen    = dma_wen_q;
  assign dma_wdata  = dma_wdata_q;
  assign dma_done   = dma_done_q;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma -- directed bench for oam_dma.
// The memory model returns the low byte of the DMA address, so every OAM write
// carries the index of the byte being copied. Outputs are sampled on the
// falling clock edge. Each cycle is compared as one packed word:
// {done, active, wen, addr, wdata}.
// -----------------------------------------------------------------------------
module tb_oam_dma;

  logic        cpu_clk = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_wen = 1'b0;
  logic [7:0]  mem_rdata;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_wen;
  logic [7:0]  dma_wdata;
  logic        dma_done;

  int total = 0;
  int bad   = 0;
  int act_cnt;
  int wen_cnt;
  int cyc;

  oam_dma dut (
    .cpu_clk   (cpu_clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wen   (cpu_wen),
    .mem_rdata (mem_rdata),
    .dma_active(dma_active),
    .dma_addr  (dma_addr),
    .dma_wen   (dma_wen),
    .dma_wdata (dma_wdata),
    .dma_done  (dma_done)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Memory model: the read data is the low byte of the address.
  assign mem_rdata = dma_addr[7:0];

  wire [31:0] obs = {5'd0, dma_done, dma_active, dma_wen, dma_addr, dma_wdata};

  // Counts rising edges since reset release; bit 0 is the expected parity.
  always @(posedge cpu_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic d, input logic a, input logic w,
                                     input logic [15:0] ad, input logic [7:0] wd);
    return {5'd0, d, a, w, ad, wd};
  endfunction

  task automatic step_cmp(input string tag, input logic [31:0] exp);
    @(negedge cpu_clk);
    if (dma_active) act_cnt++;
    if (dma_wen) wen_cnt++;
    check_val(tag, obs, exp);
  endtask

  // Trigger a transfer with the given HALT-cycle parity and check every cycle.
  // abort_idx >= 0 asserts reset during the READ of that index.
  task automatic run_xfer(input logic [7:0] page, input logic par,
                          input int abort_idx, input bit poke);
    logic al;
    al = 1'b0;
`ifdef OAM_DMA_ALIGN_EN
    al = par;
`endif
    // Parity during HALT equals bit 0 of cyc after the trigger edge.
    if (cyc[0] == par) @(negedge cpu_clk);
    cpu_addr  = 16'h4014;
    cpu_wdata = page;
    cpu_wen   = 1'b1;
    act_cnt   = 0;
    wen_cnt   = 0;
    step_cmp("halt", ev(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00));
    cpu_wen = 1'b0;
    if (al) step_cmp("align", ev(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00));
    for (int i = 0; i < 256; i++) begin
      step_cmp("read", ev(1'b0, 1'b1, 1'b0, {page, i[7:0]}, 8'h00));
      if (i == abort_idx) begin
        #1 rst_n = 1'b0;
        #1 check_val("rst_async", obs, 32'd0);
        @(negedge cpu_clk);
        check_val("rst_hold", obs, 32'd0);
        rst_n = 1'b1;
        return;
      end
      if (poke && i == 16) begin
        cpu_addr  = 16'h4014;
        cpu_wdata = 8'h05;
        cpu_wen   = 1'b1;
      end
      step_cmp("write", ev(1'b0, 1'b1, 1'b1, 16'h2004, i[7:0]));
      cpu_wen = 1'b0;
    end
    step_cmp("done", ev(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00));
    step_cmp("idle", ev(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00));
    check_val("active_len", act_cnt, 32'd513 + {31'd0, al});
    check_val("wen_cnt", wen_cnt, 32'd256);
  endtask

  initial begin
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    check_val("in_reset", obs, 32'd0);
    rst_n = 1'b1;
    step_cmp("post_reset", 32'd0);

    // Accesses that must not start a transfer.
    cpu_addr = 16'h4015; cpu_wdata = 8'h02; cpu_wen = 1'b1;
    step_cmp("wr_4015", 32'd0);
    cpu_addr = 16'h4014; cpu_wen = 1'b0;
    step_cmp("rd_4014", 32'd0);
    step_cmp("still_idle", 32'd0);

    run_xfer(8'h02, 1'b0, -1, 1'b0);
    run_xfer(8'h02, 1'b1, -1, 1'b0);
    run_xfer(8'h03, 1'b0, -1, 1'b0);
    run_xfer(8'h02, 1'b0, -1, 1'b1);
    run_xfer(8'h02, 1'b1, 8'h40, 1'b0);
    step_cmp("after_abort", 32'd0);
    run_xfer(8'hFF, 1'b0, -1, 1'b0);
    run_xfer(8'hFF, 1'b1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 Parameter DMA_REG, default 16'h4014, CPU write address that triggers a transfer.
REQ-002 Parameter OAM_DATA_REG, default 16'h2004, PPU OAMDATA address targeted by DMA writes.
REQ-003 Port cpu_clk  input  1  CPU clock from clock_gen; all state on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port cpu_addr  input  16  CPU address bus.
REQ-006 Port cpu_wdata  input  8  CPU write data.
REQ-007 Port cpu_wen  input  1  CPU write enable, high = write this cycle.
REQ-008 Port mem_rdata  input  8  bus read data for the address driven in the same cycle.
REQ-009 Port dma_active  output  1  high = DMA owns bus; CPU stalls, bus mux selects dma_* signals.
REQ-010 Port dma_addr  output  16  DMA bus address.
REQ-011 Port dma_wen  output  1  DMA write enable.
REQ-012 Port dma_wdata  output  8  DMA write data.
REQ-013 Port dma_done  output  1  one-cycle pulse after the final OAM write.

Function
REQ-014 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-015 In IDLE, cpu_wen=1 with cpu_addr==DMA_REG SHALL latch cpu_wdata as page and enter HALT next cycle.
REQ-016 HALT SHALL last exactly one cycle with dma_active=1, dma_wen=0.
REQ-017 A free-running parity bit SHALL toggle every cpu_clk from reset value 0.
REQ-018 Leaving HALT: parity==1 -> ALIGN (one cycle, dma_wen=0), else -> READ; ALIGN -> READ.
REQ-019 READ SHALL drive dma_addr={page,idx}, dma_wen=0, and capture mem_rdata into data register at cycle end.
REQ-020 WRITE SHALL drive dma_addr=OAM_DATA_REG, dma_wen=1, dma_wdata=captured byte.
REQ-021 idx (8-bit) SHALL start at 0 and increment after each WRITE; WRITE with idx==8'hFF -> IDLE, dma_done=1 in that next cycle.
REQ-022 Transfer SHALL take 513 cycles (parity 0) or 514 cycles (parity 1) of dma_active=1.
REQ-023 dma_active SHALL be high in HALT, ALIGN, READ, WRITE, low in IDLE.
REQ-024 Writes to DMA_REG while not IDLE SHALL be ignored; page SHALL not change mid-transfer.
REQ-025 idx wrap SHALL not carry into page; page 8'hFF reads 16'hFF00-16'hFFFF.
REQ-026 In IDLE, dma_addr=16'h0000, dma_wen=0, dma_wdata=8'h00.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, parity=0, idx=0, page=0, data=0, all outputs 0, including mid-transfer.
REQ-028 After rst_n deassert, a new trigger SHALL start a full transfer from idx 0.

Configuration
REQ-029 Macro OAM_DMA_ALIGN_EN defined: ALIGN state and parity logic present per REQ-018.
REQ-030 OAM_DMA_ALIGN_EN undefined: HALT always -> READ; every transfer is 513 cycles; parity logic removed.

Verification
REQ-031 Trigger write 8'h02 to 16'h4014 at parity 0 -> 513 cycles dma_active; reads 16'h0200..16'h02FF alternating with writes to 16'h2004; dma_done one pulse.
REQ-032 Same trigger at parity 1 with OAM_DMA_ALIGN_EN -> 514 active cycles, first READ one cycle later; without macro -> 513.
REQ-033 Memory model returns low byte of address; page 8'h03 -> dma_wdata sequence 8'h00..8'hFF, exactly 256 dma_wen pulses.
REQ-034 Write 8'h05 to 16'h4014 during transfer of page 8'h02 -> ignored, all reads remain in 16'h02xx.
REQ-035 Assert rst_n=0 at idx 8'h40 -> outputs 0 asynchronously; after release, trigger page 8'hFF -> full transfer 16'hFF00..16'hFFFF, no wrap into 16'h0000.
REQ-036 Write to 16'h4015 or read of 16'h4014 -> no transfer, dma_active stays 0.
